// File: rtl/ariane_pkg.sv
// ariane_pkg
// Front-end data types shared between the fetch entry issuer and decode.
//   exception_t         : cause / faulting value / valid flag
//   branchpredict_sbe_t : prediction attached to an entry (always zero here)
//   fetch_entry_t       : one instruction (or fault) handed to decode
package ariane_pkg;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [63:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;

endpackage

// File: rtl/riscv.sv
// riscv
// Minimal RISC-V architectural constants used by the fetch path:
// XLEN-wide exception cause codes for instruction-side traps.
package riscv;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] xlen_t;

    localparam xlen_t INSTR_ADDR_MISALIGNED = 64'd0;
    localparam xlen_t INSTR_ACCESS_FAULT    = 64'd1;

endpackage

// File: rtl/fetch_entry_issuer.sv
// fetch_entry_issuer
// Turns 32-bit fetch words into instruction entries for decode and buffers
// them in a DEPTH-entry circular queue.
//
// Build option: define FETCH_ENTRY_RVC_EN to enable compressed-instruction
// support. With it, each word is split into 16-bit parcels, compressed
// parcels become their own entry, and an uncompressed instruction straddling
// two words is reassembled from a held upper half. Without it, each word is
// exactly one entry and a word address with bit 1 set raises a misaligned
// fetch exception.
//
// Ports:
//   clk_i               clock, rising edge
//   rst_ni              asynchronous active-low reset
//   flush_i             drop queued entries and any held half-instruction
//   valid_i / ready_o   fetch word handshake
//   data_i              fetch word (two parcels)
//   addr_i              address of first valid parcel
//   ex_valid_i          access fault on this fetch word
//   fetch_entry_o       queue head for decode
//   fetch_entry_valid_o queue not empty
//   fetch_entry_ready_i decode consumes the head
module fetch_entry_issuer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [31:0]              data_i,
    input  logic [63:0]              addr_i,
    input  logic                     ex_valid_i,
    output ariane_pkg::fetch_entry_t fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef FETCH_ENTRY_RVC_EN
    // Leave room for the two entries a single word may produce.
    localparam logic [CW-1:0] LP_READY_MAX = CW'(DEPTH - 2);
`else
    localparam logic [CW-1:0] LP_READY_MAX = CW'(DEPTH - 1);
`endif

    ariane_pkg::fetch_entry_t r_mem [DEPTH];
    logic [PW-1:0]            r_rd_ptr;
    logic [PW-1:0]            r_wr_ptr;
    logic [CW-1:0]            r_count;

    logic                     w_accept;
    logic                     w_pop;
    logic [1:0]               w_push_cnt;
    ariane_pkg::fetch_entry_t w_entry0;
    ariane_pkg::fetch_entry_t w_entry1;

    function automatic ariane_pkg::fetch_entry_t f_entry(input logic [63:0] addr,
                                                         input logic [31:0] instr);
        f_entry             = '0;
        f_entry.address     = addr;
        f_entry.instruction = instr;
    endfunction

    function automatic ariane_pkg::fetch_entry_t f_exc(input logic [63:0] addr,
                                                       input logic [63:0] cause,
                                                       input logic [63:0] tval);
        f_exc          = '0;
        f_exc.address  = addr;
        f_exc.ex.valid = 1'b1;
        f_exc.ex.cause = cause;
        f_exc.ex.tval  = tval;
    endfunction

    assign ready_o             = (r_count <= LP_READY_MAX);
    assign fetch_entry_valid_o = (r_count != '0);
    assign fetch_entry_o       = r_mem[r_rd_ptr];
    assign w_accept            = valid_i && ready_o;
    assign w_pop               = fetch_entry_valid_o && fetch_entry_ready_i;

`ifdef FETCH_ENTRY_RVC_EN
    typedef enum logic {ALIGNED, HALF} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_held_parcel;
    logic [15:0] w_held_parcel_d;
    logic [63:0] r_held_addr;
    logic [63:0] w_held_addr_d;
    logic        w_upper_go;
    logic [63:0] w_upper_addr;

    always_comb begin
        w_push_cnt      = '0;
        w_entry0        = '0;
        w_entry1        = '0;
        w_state_d       = r_state;
        w_held_parcel_d = r_held_parcel;
        w_held_addr_d   = r_held_addr;
        w_upper_go      = 1'b0;
        w_upper_addr    = '0;
        if (w_accept) begin
            if (ex_valid_i) begin
                w_entry0   = f_exc((r_state == HALF) ? r_held_addr : addr_i,
                                   riscv::INSTR_ACCESS_FAULT, addr_i);
                w_push_cnt = 2'd1;
                w_state_d  = ALIGNED;
            end else begin
                if (r_state == HALF) begin
                    // Lower parcel completes the held instruction.
                    w_entry0     = f_entry(r_held_addr, {data_i[15:0], r_held_parcel});
                    w_push_cnt   = 2'd1;
                    w_upper_go   = 1'b1;
                    w_upper_addr = {addr_i[63:2], 2'b10};
                end else if (!addr_i[1]) begin
                    if (data_i[1:0] == 2'b11) begin
                        w_entry0   = f_entry(addr_i, data_i);
                        w_push_cnt = 2'd1;
                    end else begin
                        w_entry0     = f_entry(addr_i, {16'h0, data_i[15:0]});
                        w_push_cnt   = 2'd1;
                        w_upper_go   = 1'b1;
                        w_upper_addr = addr_i + 64'd2;
                    end
                end else begin
                    w_upper_go   = 1'b1;
                    w_upper_addr = addr_i;
                end

                if (w_upper_go) begin
                    if (data_i[17:16] != 2'b11) begin
                        if (w_push_cnt == 2'd0) begin
                            w_entry0 = f_entry(w_upper_addr, {16'h0, data_i[31:16]});
                        end else begin
                            w_entry1 = f_entry(w_upper_addr, {16'h0, data_i[31:16]});
                        end
                        w_push_cnt = w_push_cnt + 2'd1;
                        w_state_d  = ALIGNED;
                    end else begin
                        w_held_parcel_d = data_i[31:16];
                        w_held_addr_d   = w_upper_addr;
                        w_state_d       = HALF;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ALIGNED;
            r_held_parcel <= '0;
            r_held_addr   <= '0;
        end else if (flush_i) begin
            r_state       <= ALIGNED;
            r_held_parcel <= '0;
            r_held_addr   <= '0;
        end else begin
            r_state       <= w_state_d;
            r_held_parcel <= w_held_parcel_d;
            r_held_addr   <= w_held_addr_d;
        end
    end
`else
    always_comb begin
        w_push_cnt = '0;
        w_entry0   = '0;
        w_entry1   = '0;
        if (w_accept) begin
            w_push_cnt = 2'd1;
            if (ex_valid_i) begin
                w_entry0 = f_exc(addr_i, riscv::INSTR_ACCESS_FAULT, addr_i);
            end else if (addr_i[1]) begin
                w_entry0 = f_exc(addr_i, riscv::INSTR_ADDR_MISALIGNED, addr_i);
            end else begin
                w_entry0 = f_entry(addr_i, data_i);
            end
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + CW'(w_push_cnt) - CW'(w_pop);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_wr_ptr <= r_wr_ptr + PW'(w_push_cnt);
        end
    end

    // Entry storage needs no reset: count gates everything that reads it.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (w_push_cnt != 2'd0) begin
                r_mem[r_wr_ptr] <= w_entry0;
            end
            if (w_push_cnt == 2'd2) begin
                r_mem[r_wr_ptr + PW'(1)] <= w_entry1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_entry_issuer.sv
// tb_fetch_entry_issuer
// Scoreboard bench: stimulus feeds a parcel-stream reference model that
// pushes expected entries; a negedge monitor pops and compares whenever decode
// takes an entry, and checks valid/ready against the modelled queue depth.
module tb_fetch_entry_issuer;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_ENTRY_RVC_EN
    localparam int RDY_MAX = DEPTH - 2;
`else
    localparam int RDY_MAX = DEPTH - 1;
`endif

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [31:0]  data_i;
    logic [63:0]  addr_i;
    logic         ex_valid_i;
    fetch_entry_t fetch_entry_o;
    logic         fetch_entry_valid_o;
    logic         fetch_entry_ready_i;

    always #5 clk = ~clk;

    fetch_entry_issuer #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .data_i              (data_i),
        .addr_i              (addr_i),
        .ex_valid_i          (ex_valid_i),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i)
    );

    fetch_entry_t sb[$];
    int           n_cmp = 0;
    int           n_err = 0;

    // Reference model: pending half-instruction in the parcel stream.
    bit           m_pend   = 1'b0;
    logic [15:0]  m_pend_p = '0;
    logic [63:0]  m_pend_a = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [63:0] a, input logic [31:0] ins);
        fetch_entry_t e = '0;
        e.address     = a;
        e.instruction = ins;
        return e;
    endfunction

    function automatic fetch_entry_t mk_exc(input logic [63:0] a, input logic [63:0] cause,
                                            input logic [63:0] tval);
        fetch_entry_t e = '0;
        e.address  = a;
        e.ex.valid = 1'b1;
        e.ex.cause = cause;
        e.ex.tval  = tval;
        return e;
    endfunction

    function automatic void model_word(input logic [31:0] d, input logic [63:0] a, input logic ex);
`ifdef FETCH_ENTRY_RVC_EN
        logic [15:0] pp [2];
        logic [63:0] pa [2];
        int          np;
        logic [63:0] base;
        base = {a[63:2], 2'b00};
        if (ex) begin
            sb.push_back(mk_exc(m_pend ? m_pend_a : a, riscv::INSTR_ACCESS_FAULT, a));
            m_pend = 1'b0;
            return;
        end
        if (m_pend || !a[1]) begin
            pa[0] = base;      pp[0] = d[15:0];
            pa[1] = base + 2;  pp[1] = d[31:16];
            np = 2;
        end else begin
            pa[0] = a;         pp[0] = d[31:16];
            pa[1] = '0;        pp[1] = '0;
            np = 1;
        end
        if (!m_pend && !a[1]) pa[0] = a;
        for (int i = 0; i < np; i++) begin
            if (m_pend) begin
                sb.push_back(mk(m_pend_a, {pp[i], m_pend_p}));
                m_pend = 1'b0;
            end else if (pp[i][1:0] != 2'b11) begin
                sb.push_back(mk(pa[i], {16'h0, pp[i]}));
            end else begin
                m_pend   = 1'b1;
                m_pend_p = pp[i];
                m_pend_a = pa[i];
            end
        end
`else
        if (ex)        sb.push_back(mk_exc(a, riscv::INSTR_ACCESS_FAULT, a));
        else if (a[1]) sb.push_back(mk_exc(a, riscv::INSTR_ADDR_MISALIGNED, a));
        else           sb.push_back(mk(a, d));
`endif
    endfunction

    // Monitor: depth-derived flags every cycle, entry contents on each pop.
    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            chk("valid_o", 64'(fetch_entry_valid_o), 64'(sb.size() != 0));
            chk("ready_o", 64'(ready_o), 64'(sb.size() <= RDY_MAX));
            if (fetch_entry_valid_o && fetch_entry_ready_i && sb.size() != 0) begin
                fetch_entry_t exp;
                exp = sb.pop_front();
                n_cmp++;
                if (fetch_entry_o !== exp) begin
                    n_err++;
                    $display("FAIL entry: got addr=%h ins=%h exv=%b cause=%h tval=%h bp=%b, expected addr=%h ins=%h exv=%b cause=%h tval=%h",
                             fetch_entry_o.address, fetch_entry_o.instruction, fetch_entry_o.ex.valid,
                             fetch_entry_o.ex.cause, fetch_entry_o.ex.tval, fetch_entry_o.branch_predict.valid,
                             exp.address, exp.instruction, exp.ex.valid, exp.ex.cause, exp.ex.tval);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic [63:0] a,
                        input logic ex, input logic fl, input logic rdy);
        @(posedge clk);
        #1;
        valid_i = v; data_i = d; addr_i = a; ex_valid_i = ex;
        flush_i = fl; fetch_entry_ready_i = rdy;
        @(negedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_pend = 1'b0;
        end else if (v && ready_o) begin
            model_word(d, a, ex);
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [63:0] a;
        int          guard;

        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
        addr_i = '0; ex_valid_i = 1'b0; fetch_entry_ready_i = 1'b0;
        #3;
        chk("rst_valid", 64'(fetch_entry_valid_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Directed words (expected entries come from the model for this build).
        step(1'b1, 32'h0000_0013, 64'h1000, 1'b0, 1'b0, 1'b1);
        chk("latency_same_cycle", 64'(fetch_entry_valid_o), 64'd0);
        idle(1'b1);
        step(1'b1, 32'h4501_4485, 64'h2000, 1'b0, 1'b0, 1'b1);
        idle(1'b1); idle(1'b1);
        step(1'b1, 32'h0013_4501, 64'h3000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hAAAA_0000, 64'h3004, 1'b0, 1'b0, 1'b1);
        idle(1'b1); idle(1'b1);
        step(1'b1, 32'hFFFF_4501, 64'h4000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h1234_5678, 64'h4006, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0013, 64'h5002, 1'b0, 1'b0, 1'b1);
        repeat (3) idle(1'b1);

        // Fill without draining, then flush.
        guard = 0;
        while (ready_o && guard < 8) begin
            step(1'b1, 32'h0000_0013, 64'h6000 + 64'(guard * 4), 1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("fill_ready_low", 64'(ready_o), 64'd0);
        step(1'b1, 32'h0000_0013, 64'h7000, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        chk("flush_valid", 64'(fetch_entry_valid_o), 64'd0);
        chk("flush_ready", 64'(ready_o), 64'd1);

        // Asynchronous reset with three queued entries.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h0000_0013, 64'h8000 + 64'(i * 4), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 valid_i = 1'b0;
        #1 rst_ni = 1'b0;
        sb.delete();
        m_pend = 1'b0;
        #1;
        chk("async_rst_valid", 64'(fetch_entry_valid_o), 64'd0);
        chk("async_rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (3) idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[1:0]   = 2'b11;
            if ($urandom_range(0, 3) == 0) d[17:16] = 2'b11;
            a = {$urandom, $urandom};
            a[0] = 1'b0;
            a[1] = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0, d, a,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 7);
        end

        // Drain, bounded.
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            idle(1'b1);
            guard++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d entries still expected, required 0", sb.size());
        end
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
